// File: rtl/seq_sched_pkg.sv
// Shared definitions for the pattern scan scheduler.
//   state_e     : scheduler FSM encoding (idle / stream / report)
//   DefPlen     : default pattern length
//   DefPattern  : default target sequence, MSB received first
//   rr_select() : round-robin pick of the first requester at or above a pointer, wrapping
package seq_sched_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StStream = 2'd1,
    StReport = 2'd2
  } state_e;

  localparam int unsigned DefPlen = 5;
  localparam logic [DefPlen-1:0] DefPattern = 5'b11101;

  // Upper bound on the number of channels the select function can scan.
  localparam int unsigned MaxNch = 32;

  // Returns the index of the first set bit of req searching upward from ptr modulo nch.
  // Returns ptr when no bit is set; callers only use the result when |req.
  function automatic int unsigned rr_select(input logic [MaxNch-1:0] req,
                                            input int unsigned ptr,
                                            input int unsigned nch);
    int unsigned idx;
    logic found;
    rr_select = ptr;
    found = 1'b0;
    for (int unsigned i = 0; i < MaxNch; i++) begin
      if (!found && i < nch) begin
        idx = ptr + i;
        if (idx >= nch) idx = idx - nch;
        if (req[idx[4:0]]) begin
          rr_select = idx;
          found = 1'b1;
        end
      end
    end
  endfunction

endpackage

// File: rtl/pattern_scan_scheduler_if.sv
// Serial channel bus between the front-end requesters and the scheduler.
//   req       : per-channel frame pending
//   bit_in    : per-channel serial data
//   bit_valid : per-channel data valid
//   bit_ready : one-hot ready from the scheduler to the granted channel
// master = requesters side, slave = scheduler side.
interface pattern_scan_scheduler_if #(
  parameter int unsigned NCH = 4
);
  logic [NCH-1:0] req;
  logic [NCH-1:0] bit_in;
  logic [NCH-1:0] bit_valid;
  logic [NCH-1:0] bit_ready;

  modport master (output req, output bit_in, output bit_valid, input bit_ready);
  modport slave  (input req, input bit_in, input bit_valid, output bit_ready);
endinterface

// File: rtl/pattern_match_core.sv
// Bit-serial matcher: PLEN-bit history shift register plus a fill counter.
//   clk_i, rst_i : clock, synchronous active-high reset
//   shift_en_i   : shift bit_i into the history this cycle
//   bit_i        : serial data bit
//   clear_i      : clear history and fill (frame start)
//   overlap_i    : 1 keeps history after a match, 0 restarts the fill
//   hit_o        : combinational, the bit being shifted completes a match
//   match_o      : registered one-cycle match pulse
module pattern_match_core
  import seq_sched_pkg::*;
#(
  parameter int unsigned      PLEN    = DefPlen,
  parameter logic [PLEN-1:0]  PATTERN = DefPattern
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic shift_en_i,
  input  logic bit_i,
  input  logic clear_i,
  input  logic overlap_i,
  output logic hit_o,
  output logic match_o
);

  localparam int unsigned FillW = $clog2(PLEN + 1);

  logic [PLEN-1:0]  hist_q, hist_d, hist_shift;
  logic [FillW-1:0] fill_q, fill_d, fill_inc;
  logic             match_q, match_d;

  always_comb begin
    hist_shift = {hist_q[PLEN-2:0], bit_i};
    // Fill saturates at PLEN: it only gates whether the history is fully populated.
    fill_inc   = (fill_q == FillW'(PLEN)) ? fill_q : fill_q + 1'b1;
    hit_o      = shift_en_i && !clear_i && (fill_inc == FillW'(PLEN)) && (hist_shift == PATTERN);
    hist_d     = hist_q;
    fill_d     = fill_q;
    match_d    = hit_o;
    if (clear_i) begin
      hist_d = '0;
      fill_d = '0;
    end else if (shift_en_i) begin
      hist_d = hist_shift;
      fill_d = (hit_o && !overlap_i) ? '0 : fill_inc;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hist_q  <= '0;
      fill_q  <= '0;
      match_q <= 1'b0;
    end else begin
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      match_q <= match_d;
    end
  end

  assign match_o = match_q;

endmodule

// File: rtl/pattern_scan_scheduler.sv
// Round-robin scheduler sharing one bit-serial pattern matcher among NCH channels.
//   clock, reset   : clock, synchronous active-high reset
//   chan           : channel bus (req, bit_in, bit_valid in; bit_ready out)
//   overlap_en_i   : overlapping matches counted, sampled at grant
//   abort_i        : ends the current frame early
//   grant_o        : registered one-hot granted channel
//   busy_o         : scheduler not idle
//   match_pulse_o  : one-cycle pulse per detected match
//   done_o         : one-cycle pulse at end of frame
//   done_ch_o      : channel of the last completed frame
//   match_count_o  : matches in the current or last completed frame
//   aborted_o      : last completed frame was aborted
module pattern_scan_scheduler
  import seq_sched_pkg::*;
#(
  parameter int unsigned     NCH       = 4,
  parameter int unsigned     CH_W      = 2,
  parameter int unsigned     PLEN      = DefPlen,
  parameter logic [PLEN-1:0] PATTERN   = DefPattern,
  parameter int unsigned     FRAME_LEN = 16,
  parameter int unsigned     CNT_W     = 5
) (
  input  logic                     clock,
  input  logic                     reset,
  pattern_scan_scheduler_if.slave  chan,
  input  logic                     overlap_en_i,
  input  logic                     abort_i,
  output logic [NCH-1:0]           grant_o,
  output logic                     busy_o,
  output logic                     match_pulse_o,
  output logic                     done_o,
  output logic [CH_W-1:0]          done_ch_o,
  output logic [CNT_W-1:0]         match_count_o,
  output logic                     aborted_o
);

  state_e            state_q, state_d;
  logic [NCH-1:0]    grant_q, grant_d;
  logic [CH_W-1:0]   gidx_q, gidx_d;
  logic [CH_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              ovl_q, ovl_d;
  logic [CH_W-1:0]   done_ch_q, done_ch_d;
  logic              aborted_q, aborted_d;

  logic              accept, cur_bit, start, hit;
  logic [CH_W-1:0]   sel;

  // grant_q is non-zero only in StStream, so masking with it both selects the
  // channel and qualifies the handshake.
  assign accept = |(chan.bit_valid & grant_q);
  assign cur_bit = |(chan.bit_in & grant_q);
  assign start  = (state_q == StIdle) && (|chan.req);
  assign sel    = CH_W'(rr_select(MaxNch'(chan.req), 32'(rr_ptr_q), NCH));

  pattern_match_core #(
    .PLEN    (PLEN),
    .PATTERN (PATTERN)
  ) u_core (
    .clk_i      (clock),
    .rst_i      (reset),
    .shift_en_i (accept),
    .bit_i      (cur_bit),
    .clear_i    (start),
    .overlap_i  (ovl_q),
    .hit_o      (hit),
    .match_o    (match_pulse_o)
  );

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    gidx_d    = gidx_q;
    rr_ptr_d  = rr_ptr_q;
    bit_cnt_d = bit_cnt_q;
    count_d   = count_q;
    ovl_d     = ovl_q;
    done_ch_d = done_ch_q;
    aborted_d = aborted_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          grant_d   = NCH'(1) << sel;
          gidx_d    = sel;
          bit_cnt_d = '0;
          count_d   = '0;
          ovl_d     = overlap_en_i;
          state_d   = StStream;
        end
      end
      StStream: begin
        if (accept) bit_cnt_d = bit_cnt_q + 1'b1;
        if (hit && count_q != '1) count_d = count_q + 1'b1;
        if (abort_i || (accept && bit_cnt_q == CNT_W'(FRAME_LEN - 1))) begin
          state_d   = StReport;
          grant_d   = '0;
          done_ch_d = gidx_q;
          aborted_d = abort_i;
          rr_ptr_d  = (gidx_q == CH_W'(NCH - 1)) ? '0 : gidx_q + 1'b1;
        end
      end
      StReport: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= StIdle;
      grant_q   <= '0;
      gidx_q    <= '0;
      rr_ptr_q  <= '0;
      bit_cnt_q <= '0;
      count_q   <= '0;
      ovl_q     <= 1'b0;
      done_ch_q <= '0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      gidx_q    <= gidx_d;
      rr_ptr_q  <= rr_ptr_d;
      bit_cnt_q <= bit_cnt_d;
      count_q   <= count_d;
      ovl_q     <= ovl_d;
      done_ch_q <= done_ch_d;
      aborted_q <= aborted_d;
    end
  end

  assign chan.bit_ready = grant_q;
  assign grant_o        = grant_q;
  assign busy_o         = (state_q != StIdle);
  assign done_o         = (state_q == StReport);
  assign done_ch_o      = done_ch_q;
  assign match_count_o  = count_q;
  assign aborted_o      = aborted_q;

endmodule

// File: tb/tb_pattern_scan_scheduler.sv
// Self-checking bench: per-cycle comparison against a frame-level model plus
// hand-computed expectations for each directed scenario.
module tb_pattern_scan_scheduler;

  localparam int NCH       = 4;
  localparam int PLEN      = 5;
  localparam int FRAME_LEN = 16;
  localparam int CNT_MAX   = 31;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pattern_scan_scheduler_if #(.NCH(NCH)) chan ();

  logic       ovl_en, abort;
  logic [3:0] grant;
  logic       busy, match_pulse, done, aborted;
  logic [1:0] done_ch;
  logic [4:0] match_count;

  pattern_scan_scheduler dut (
    .clock         (clk),
    .reset         (rst),
    .chan          (chan),
    .overlap_en_i  (ovl_en),
    .abort_i       (abort),
    .grant_o       (grant),
    .busy_o        (busy),
    .match_pulse_o (match_pulse),
    .done_o        (done),
    .done_ch_o     (done_ch),
    .match_count_o (match_count),
    .aborted_o     (aborted)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- stimulus sources ----------------
  logic [15:0] src [NCH];
  int          ptr [NCH];
  logic        stall_en, stall_tgl, vmask;

  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      chan.bit_in[i] = (ptr[i] < FRAME_LEN) ? src[i][15 - ptr[i]] : 1'b0;
    end
    chan.bit_valid = (vmask && (!stall_en || stall_tgl)) ? 4'b1111 : 4'b0000;
  end

  // Each channel restarts its frame after it has been reported.
  always @(posedge clk) begin
    stall_tgl <= rst ? 1'b1 : ~stall_tgl;
    for (int i = 0; i < NCH; i++) begin
      if (rst || (done && done_ch == 2'(i))) ptr[i] <= 0;
      else if (chan.bit_valid[i] && chan.bit_ready[i]) ptr[i] <= ptr[i] + 1;
    end
  end

  // ---------------- model ----------------
  int   m_phase;  // 0 idle, 1 streaming, 2 reporting
  int   m_g, m_ptr, m_n, m_cnt, m_done_ch, m_since;
  bit   m_ok = 1'b0;
  bit   m_ovl, m_pulse, m_aborted, m_found, m_acc, m_hit;
  bit   m_bits[$];
  logic [PLEN-1:0] pat = 5'b11101;

  always @(posedge clk) begin
    if (rst) begin
      m_ok = 1'b1; m_phase = 0; m_g = 0; m_ptr = 0; m_n = 0; m_cnt = 0;
      m_done_ch = 0; m_since = 0; m_pulse = 0; m_aborted = 0; m_ovl = 0;
      m_bits.delete();
    end else begin
      m_pulse = 1'b0;
      if (m_phase == 0) begin
        if (chan.req != 4'b0000) begin
          m_found = 1'b0;
          for (int k = 0; k < NCH; k++) begin
            if (!m_found && chan.req[(m_ptr + k) % NCH]) begin
              m_g = (m_ptr + k) % NCH;
              m_found = 1'b1;
            end
          end
          m_n = 0; m_cnt = 0; m_since = 0; m_ovl = ovl_en; m_bits.delete();
          m_phase = 1;
        end
      end else if (m_phase == 1) begin
        m_acc = chan.bit_valid[m_g];
        if (m_acc) begin
          m_bits.push_back(chan.bit_in[m_g]);
          m_n++;
          m_hit = 1'b0;
          if (m_bits.size() - m_since >= PLEN) begin
            m_hit = 1'b1;
            for (int k = 0; k < PLEN; k++)
              if (m_bits[m_bits.size() - PLEN + k] != pat[PLEN - 1 - k]) m_hit = 1'b0;
          end
          if (m_hit) begin
            m_pulse = 1'b1;
            if (m_cnt < CNT_MAX) m_cnt++;
            if (!m_ovl) m_since = m_bits.size();
          end
        end
        if (abort || (m_acc && m_n == FRAME_LEN)) begin
          m_phase = 2; m_done_ch = m_g; m_aborted = abort; m_ptr = (m_g + 1) % NCH;
        end
      end else begin
        m_phase = 0;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (m_ok) begin
      chk("grant", 32'(grant), (m_phase == 1) ? (32'd1 << m_g) : 32'd0);
      chk("bit_ready", 32'(chan.bit_ready), (m_phase == 1) ? (32'd1 << m_g) : 32'd0);
      chk("busy", 32'(busy), 32'(m_phase != 0));
      chk("done", 32'(done), 32'(m_phase == 2));
      chk("done_ch", 32'(done_ch), 32'(m_done_ch));
      chk("aborted", 32'(aborted), 32'(m_aborted));
      chk("match_count", 32'(match_count), 32'(m_cnt));
      chk("match_pulse", 32'(match_pulse), 32'(m_pulse));
    end
  end

  // ---------------- directed scenarios ----------------
  task automatic wait_done(input int maxc, input string name, output bit seen);
    seen = 1'b0;
    for (int c = 0; c < maxc && !seen; c++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL %s: done not seen within %0d cycles", name, maxc);
    end
  endtask

  task automatic run_single(input logic [3:0] r, input logic [3:0] exp_g, input logic ov,
                            input int exp_cnt, input int exp_ch, input string name);
    bit seen;
    chan.req = r; ovl_en = ov;
    @(negedge clk);
    chk({name, "_grant"}, 32'(grant), 32'(exp_g));
    chan.req = 4'b0000;
    wait_done(120, name, seen);
    if (seen) begin
      chk({name, "_count"}, 32'(match_count), 32'(exp_cnt));
      chk({name, "_ch"}, 32'(done_ch), 32'(exp_ch));
      chk({name, "_aborted"}, 32'(aborted), 32'd0);
    end
    @(negedge clk);
  endtask

  initial begin
    bit seen;
    int exp_seq [5] = '{0, 1, 2, 3, 0};
    chan.req = 4'b0000; ovl_en = 1'b0; abort = 1'b0; stall_en = 1'b0; vmask = 1'b1;
    src[0] = 16'b1110111010000000;
    src[1] = 16'b1110111101000000;
    src[2] = 16'b1110100000000000;
    src[3] = 16'b0011101110100000;
    repeat (3) @(negedge clk);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_count", 32'(match_count), 32'd0);
    rst = 1'b0;

    // Single requester on channel 2, one match.
    run_single(4'b0100, 4'b0100, 1'b0, 1, 2, "single");
    // Overlap vs non-overlap on channel 0.
    run_single(4'b0001, 4'b0001, 1'b1, 2, 0, "ovl_on");
    run_single(4'b0001, 4'b0001, 1'b0, 1, 0, "ovl_off");

    // Round robin from a fresh pointer.
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chan.req = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      wait_done(60, "rr", seen);
      if (seen) chk($sformatf("rr_ch%0d", n), 32'(done_ch), 32'(exp_seq[n]));
    end
    chan.req = 4'b0000;
    @(negedge clk);

    // Stalled stream on channel 2 gives the same result as unstalled.
    stall_en = 1'b1;
    run_single(4'b0100, 4'b0100, 1'b0, 1, 2, "stall");
    stall_en = 1'b0;

    // Abort after 7 accepts on channel 1, then channel 2 is next.
    chan.req = 4'b0110;
    @(negedge clk);
    chk("abort_grant", 32'(grant), 32'b0010);
    seen = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      if (ptr[1] == 7) seen = 1'b1;
      else @(negedge clk);
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL abort_wait: 7 accepts not reached");
    end
    abort = 1'b1; vmask = 1'b0;
    @(negedge clk);
    abort = 1'b0; vmask = 1'b1;
    chk("abort_done", 32'(done), 32'd1);
    chk("abort_flag", 32'(aborted), 32'd1);
    chk("abort_count", 32'(match_count), 32'd1);
    chk("abort_ch", 32'(done_ch), 32'd1);
    @(negedge clk);
    @(negedge clk);
    chk("abort_next_grant", 32'(grant), 32'b0100);
    chan.req = 4'b0000;
    wait_done(60, "abort_next", seen);
    if (seen) chk("abort_next_count", 32'(match_count), 32'd1);
    @(negedge clk);

    // Reset mid-stream: no done, pointer back to channel 0.
    chan.req = 4'b0001;
    @(negedge clk);
    chan.req = 4'b0000;
    seen = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      if (ptr[0] == 5) seen = 1'b1;
      else @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_grant", 32'(grant), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    rst = 1'b0;
    chan.req = 4'b1001;
    @(negedge clk);
    chk("post_rst_grant", 32'(grant), 32'b0001);
    chan.req = 4'b0000;
    wait_done(60, "post_rst", seen);
    if (seen) chk("post_rst_count", 32'(match_count), 32'd1);
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
